axi_sram_slave: RTL

AXI_SRAM_SLAVE -- requirements
Module: axi_sram_slave

---
 rtl/axi_pkg.sv | 28 ++
 rtl/sram_1r1w.sv | 30 +++
 rtl/axi_sram_slave.sv | 210 +++++++++++++++++++++
 3 files changed

// File: rtl/axi_pkg.sv
// Shared AXI definitions: response encodings, write/read FSM state types,
// and the default byte-address width macro ADDR_WIDTH.
`ifndef ADDR_WIDTH
`define ADDR_WIDTH 32
`endif

package axi_pkg;

    localparam int AXI_ADDR_WIDTH = `ADDR_WIDTH;

    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_SLVERR = 2'b10;
    localparam logic [1:0] RESP_DECERR = 2'b11;

    typedef enum logic [1:0] {
        W_IDLE   = 2'd0,
        W_HAVE_A = 2'd1,
        W_HAVE_D = 2'd2,
        W_RESP   = 2'd3
    } wr_state_t;

    typedef enum logic [1:0] {
        R_IDLE = 2'd0,
        R_MEM  = 2'd1,
        R_DATA = 2'd2
    } rd_state_t;

endpackage

// File: rtl/sram_1r1w.sv
// Simple dual-port word memory: one write port, one registered read port
// (read-first on same-address collision), contents never reset.
module sram_1r1w #(
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_BITS  = 10
) (
    input  logic                  clk,
    input  logic                  i_we,
    input  logic [ADDR_BITS-1:0]  i_waddr,
    input  logic [DATA_WIDTH-1:0] i_wdata,
    input  logic                  i_re,
    input  logic [ADDR_BITS-1:0]  i_raddr,
    output logic [DATA_WIDTH-1:0] o_rdata
);

    logic [DATA_WIDTH-1:0] r_mem [0:(1<<ADDR_BITS)-1];
    logic [DATA_WIDTH-1:0] r_rdata;

    always_ff @(posedge clk) begin
        if (i_we) begin
            r_mem[i_waddr] <= i_wdata;
        end
        if (i_re) begin
            r_rdata <= r_mem[i_raddr];
        end
    end

    assign o_rdata = r_rdata;

endmodule

// File: rtl/axi_sram_slave.sv
// Single-beat AXI slave in front of a 32-bit word SRAM with independent read and
// write FSMs. Define AXI_SRAM_RANGE_CHK_EN to answer out-of-window accesses with DECERR.
`ifndef ADDR_WIDTH
`define ADDR_WIDTH 32
`endif

module axi_sram_slave
    import axi_pkg::*;
#(
    parameter int                    ADDR_WIDTH = `ADDR_WIDTH,
    parameter int                    DEPTH_LOG2 = 10,
    parameter logic [ADDR_WIDTH-1:0] BASE_ADDR  = '0
) (
    input  logic                  clk,
    input  logic                  rst,

    input  logic [ADDR_WIDTH-1:0] awaddr,
    input  logic                  awvalid,
    input  logic [7:0]            awlen,
    input  logic [2:0]            awsize,
    input  logic [1:0]            awburst,
    output logic                  awready,

    input  logic [31:0]           wdata,
    input  logic                  wvalid,
    input  logic                  wlast,
    output logic                  wready,

    output logic [1:0]            bresp,
    output logic                  bvalid,
    input  logic                  bready,

    input  logic [ADDR_WIDTH-1:0] araddr,
    input  logic                  arvalid,
    input  logic [7:0]            arlen,
    input  logic [2:0]            arsize,
    input  logic [1:0]            arburst,
    output logic                  arready,

    output logic [31:0]           rdata,
    output logic [1:0]            rresp,
    output logic                  rlast,
    output logic                  rvalid,
    input  logic                  rready
);

    function automatic logic [DEPTH_LOG2-1:0] word_idx(input logic [ADDR_WIDTH-1:0] a);
        return DEPTH_LOG2'((a - BASE_ADDR) >> 2);
    endfunction

`ifdef AXI_SRAM_RANGE_CHK_EN
    function automatic logic in_range(input logic [ADDR_WIDTH-1:0] a);
        return (a >= BASE_ADDR) && (((a - BASE_ADDR) >> (DEPTH_LOG2 + 2)) == '0);
    endfunction
`endif

    // Burst/size/last fields are irrelevant for single-beat transfers.
    logic w_unused;
    assign w_unused = ^{awlen, awsize, awburst, arlen, arsize, arburst, wlast};

    // ---------------- write path ----------------
    wr_state_t             r_wstate, w_wstate_next;
    logic [ADDR_WIDTH-1:0] r_awaddr;
    logic [31:0]           r_wdata;
    logic [1:0]            r_bresp;
    logic                  w_aw_hs, w_w_hs, w_commit, w_wr_ok, w_mem_we;
    logic [ADDR_WIDTH-1:0] w_commit_addr;
    logic [31:0]           w_commit_data;

    assign awready = (r_wstate == W_IDLE) || (r_wstate == W_HAVE_D);
    assign wready  = (r_wstate == W_IDLE) || (r_wstate == W_HAVE_A);
    assign w_aw_hs = awvalid && awready;
    assign w_w_hs  = wvalid && wready;

    assign w_commit_addr = (r_wstate == W_HAVE_A) ? r_awaddr : awaddr;
    assign w_commit_data = (r_wstate == W_HAVE_D) ? r_wdata  : wdata;

`ifdef AXI_SRAM_RANGE_CHK_EN
    assign w_wr_ok = in_range(w_commit_addr);
`else
    assign w_wr_ok = 1'b1;
`endif

    always_comb begin
        w_wstate_next = r_wstate;
        w_commit      = 1'b0;
        case (r_wstate)
            W_IDLE: begin
                if (w_aw_hs && w_w_hs) begin
                    w_commit      = 1'b1;
                    w_wstate_next = W_RESP;
                end else if (w_aw_hs) begin
                    w_wstate_next = W_HAVE_A;
                end else if (w_w_hs) begin
                    w_wstate_next = W_HAVE_D;
                end
            end
            W_HAVE_A: begin
                if (w_w_hs) begin
                    w_commit      = 1'b1;
                    w_wstate_next = W_RESP;
                end
            end
            W_HAVE_D: begin
                if (w_aw_hs) begin
                    w_commit      = 1'b1;
                    w_wstate_next = W_RESP;
                end
            end
            W_RESP: begin
                if (bready) begin
                    w_wstate_next = W_IDLE;
                end
            end
            default: w_wstate_next = W_IDLE;
        endcase
    end

    // A commit coinciding with an asserted reset must never reach the array.
    assign w_mem_we = w_commit && w_wr_ok && !rst;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_wstate <= W_IDLE;
            r_awaddr <= '0;
            r_wdata  <= '0;
            r_bresp  <= RESP_OKAY;
        end else begin
            r_wstate <= w_wstate_next;
            if (w_aw_hs) begin
                r_awaddr <= awaddr;
            end
            if (w_w_hs) begin
                r_wdata <= wdata;
            end
            if (w_commit) begin
                r_bresp <= w_wr_ok ? RESP_OKAY : RESP_DECERR;
            end
        end
    end

    assign bvalid = (r_wstate == W_RESP);
    assign bresp  = bvalid ? r_bresp : RESP_OKAY;

    // ---------------- read path ----------------
    rd_state_t   r_rstate;
    logic        r_rerr;
    logic [31:0] r_rdata;
    logic        w_ar_hs, w_rd_ok, w_mem_re;
    logic [31:0] w_mem_rdata;

    assign arready = (r_rstate == R_IDLE);
    assign w_ar_hs = arvalid && arready;

`ifdef AXI_SRAM_RANGE_CHK_EN
    assign w_rd_ok = in_range(araddr);
`else
    assign w_rd_ok = 1'b1;
`endif

    // The array is sampled on the AR handshake edge, so a write committing on
    // that same edge is not visible to this read.
    assign w_mem_re = w_ar_hs && w_rd_ok;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_rstate <= R_IDLE;
            r_rerr   <= 1'b0;
            r_rdata  <= '0;
        end else begin
            case (r_rstate)
                R_IDLE: begin
                    if (w_ar_hs) begin
                        r_rstate <= R_MEM;
                        r_rerr   <= !w_rd_ok;
                    end
                end
                R_MEM: begin
                    r_rdata  <= r_rerr ? '0 : w_mem_rdata;
                    r_rstate <= R_DATA;
                end
                R_DATA: begin
                    if (rready) begin
                        r_rstate <= R_IDLE;
                    end
                end
                default: r_rstate <= R_IDLE;
            endcase
        end
    end

    assign rvalid = (r_rstate == R_DATA);
    assign rlast  = rvalid;
    assign rresp  = (rvalid && r_rerr) ? RESP_DECERR : RESP_OKAY;
    assign rdata  = r_rdata;

    sram_1r1w #(
        .DATA_WIDTH (32),
        .ADDR_BITS  (DEPTH_LOG2)
    ) u_sram (
        .clk     (clk),
        .i_we    (w_mem_we),
        .i_waddr (word_idx(w_commit_addr)),
        .i_wdata (w_commit_data),
        .i_re    (w_mem_re),
        .i_raddr (word_idx(araddr)),
        .o_rdata (w_mem_rdata)
    );

endmodule
